// File: rtl/dlx_isa_pkg.sv
// Shared DLX ISA definitions: opcodes, request kinds and instruction field positions.
// Words are held as [31:0]; DLX bit index i (0 = MSB) corresponds to vector bit 31-i.
package dlx_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LHI   = 6'h0F;

    typedef enum logic [2:0] {
        KIND_NOP   = 3'd0,
        KIND_RTYPE = 3'd1,
        KIND_ITYPE = 3'd2,
        KIND_JTYPE = 3'd3,
        KIND_LI32  = 3'd4
    } req_kind_t;

    // Field positions in [31:0] numbering (DLX [0:5] opcode is [31:26], etc.)
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS1_HI   = 25;
    localparam int RS1_LO   = 21;
    localparam int RS2_HI   = 20;
    localparam int RS2_LO   = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNC_HI  = 5;
    localparam int FUNC_LO  = 0;
    localparam int IMM16_HI = 15;
    localparam int IMM16_LO = 0;
    localparam int IMM26_HI = 25;
    localparam int IMM26_LO = 0;

endpackage

// File: rtl/dlx_field_pack.sv
// Combinational packer: turns one field-level request into up to two DLX words
// and flags requests that are illegal or whose immediate does not fit.
module dlx_field_pack
    import dlx_isa_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic [31:0] word1,
    output logic [31:0] word2,
    output logic        has_word2,
    output logic        emit,
    output logic        flag_err
);

    // Field placement per request kind; LI32 splits into LHI + optional ORI
    always_comb begin
        word1     = '0;
        word2     = '0;
        has_word2 = 1'b0;
        emit      = 1'b1;
        flag_err  = 1'b0;
        case (kind)
            KIND_NOP: begin
                word1 = '0;
            end
            KIND_RTYPE: begin
                word1[OPC_HI:OPC_LO]   = OP_RTYPE;
                word1[RS1_HI:RS1_LO]   = rs1;
                word1[RS2_HI:RS2_LO]   = rs2;
                word1[RD_HI:RD_LO]     = rd;
                word1[FUNC_HI:FUNC_LO] = func;
            end
            KIND_ITYPE: begin
                word1[OPC_HI:OPC_LO]     = opcode;
                word1[RS1_HI:RS1_LO]     = rs1;
                word1[RS2_HI:RS2_LO]     = rd;
                word1[IMM16_HI:IMM16_LO] = imm[15:0];
                // top 17 bits must be a pure sign extension
                flag_err = !((&imm[31:15]) || !(|imm[31:15]));
            end
            KIND_JTYPE: begin
                word1[OPC_HI:OPC_LO]     = opcode;
                word1[IMM26_HI:IMM26_LO] = imm[25:0];
                flag_err = !((&imm[31:25]) || !(|imm[31:25]));
            end
            KIND_LI32: begin
                word1[OPC_HI:OPC_LO]     = OP_LHI;
                word1[RS2_HI:RS2_LO]     = rd;
                word1[IMM16_HI:IMM16_LO] = imm[31:16];
                word2[OPC_HI:OPC_LO]     = OP_ORI;
                word2[RS1_HI:RS1_LO]     = rd;
                word2[RS2_HI:RS2_LO]     = rd;
                word2[IMM16_HI:IMM16_LO] = imm[15:0];
                has_word2 = |imm[15:0];
            end
            default: begin
                emit     = 1'b0;
                flag_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dlx_instr_encoder.sv
// Streaming DLX instruction encoder: accepts field requests, emits packed words
// with word-aligned byte addresses, expanding LI32 into LHI/ORI.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | output register empty (or just drained)
// ST_HOLD1 | word held in output register, nothing pending behind it
// ST_HOLD2 | LHI held in output register, ORI waiting in ori_word
module dlx_instr_encoder
    import dlx_isa_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [5:0]        req_opcode,
    input  logic [5:0]        req_func,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [4:0]        req_rd,
    input  logic [31:0]       req_imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD1 = 2'd1,
        ST_HOLD2 = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       ori_word;
    logic [ADDR_W-1:0] next_addr;

    logic [31:0]       pk_word1;
    logic [31:0]       pk_word2;
    logic              pk_has2;
    logic              pk_emit;
    logic              pk_err;

    logic              accept;
    logic              drain;
    logic [ADDR_W-1:0] base_aligned;
    logic [ADDR_W-1:0] load_addr;

    dlx_field_pack u_pack (
        .kind      (req_kind),
        .opcode    (req_opcode),
        .func      (req_func),
        .rs1       (req_rs1),
        .rs2       (req_rs2),
        .rd        (req_rd),
        .imm       (req_imm),
        .word1     (pk_word1),
        .word2     (pk_word2),
        .has_word2 (pk_has2),
        .emit      (pk_emit),
        .flag_err  (pk_err)
    );

    // Handshake and address selection; base_load overrides the running counter
    assign req_ready    = (state != ST_HOLD2) && (!out_valid || out_ready);
    assign accept       = req_valid && req_ready;
    assign drain        = out_valid && out_ready;
    assign base_aligned = base_addr & ~ADDR_W'(3);
    assign load_addr    = base_load ? base_aligned : next_addr;

    // Sequencer, output register and address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_addr  <= '0;
            next_addr <= '0;
            ori_word  <= '0;
            err       <= 1'b0;
        end else begin
            err <= accept && pk_err;
            if (state == ST_HOLD2) begin
                if (out_ready) begin
                    out_word  <= ori_word;
                    out_addr  <= load_addr;
                    next_addr <= load_addr + ADDR_W'(4);
                    state     <= ST_HOLD1;
                end else if (base_load) begin
                    next_addr <= base_aligned;
                end
            end else if (accept && pk_emit) begin
                out_valid <= 1'b1;
                out_word  <= pk_word1;
                out_addr  <= load_addr;
                next_addr <= load_addr + ADDR_W'(4);
                ori_word  <= pk_word2;
                state     <= pk_has2 ? ST_HOLD2 : ST_HOLD1;
            end else begin
                if (base_load) begin
                    next_addr <= base_aligned;
                end
                if (drain) begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            end
        end
    end

endmodule
